// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch-side PC controller.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int ADDR_W = 32;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  localparam logic [ADDR_W-1:0] EXC_VECTOR       = 32'h0000_4180;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] INSN_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_npc_target.sv
// Redirect target computation for branch/jump/jr with priority jr > jump > branch.
module npc_target
  import pc_pkg::*;
(
  input  logic              branch,
  input  logic [IMM_W-1:0]  br_imm16,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              jump,
  input  logic [JIDX_W-1:0] j_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0]        seq_pc;
  logic signed [ADDR_W-1:0] br_off;
  logic                     any_redir;

  always_comb begin
    any_redir = branch | jump | jr;
    seq_pc    = id_pc + INSN_BYTES;
    br_off    = {{14{br_imm16[IMM_W-1]}}, br_imm16, 2'b00};
    // branch is the fallback when nothing higher-priority is asserted
    target    = seq_pc + $unsigned(br_off);
    if (jr) begin
      target = jr_target & ~32'h0000_0003;
    end else if (jump) begin
      target = {seq_pc[31:28], j_index, 2'b00};
    end else if (!any_redir) begin
      target = seq_pc;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC controller with one-slot branch delay handling and imem ready handshake.
// Optional exception redirect enabled by defining PC_EXC_EN.
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] br_imm16,
  input  logic [31:0] id_pc,
  input  logic        jump,
  input  logic [25:0] j_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        imem_ready,
`ifdef PC_EXC_EN
  input  logic        exc_req,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        redirect_pending
);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pend_tgt;
  logic [31:0] target;
  logic        accept;
  logic        redir;

  npc_target u_npc_target (
    .branch    (branch),
    .br_imm16  (br_imm16),
    .id_pc     (id_pc),
    .jump      (jump),
    .j_index   (j_index),
    .jr        (jr),
    .jr_target (jr_target),
    .target    (target)
  );

  assign accept    = (state != BOOT) && imem_ready && !stall;
  assign redir     = (branch | jump | jr) && !stall;
  assign imem_req  = (state != BOOT);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!imem_ready) state_nxt = WAIT;
      WAIT:    if (imem_ready) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
`ifdef PC_EXC_EN
    if (exc_req) state_nxt = RUN;
`endif
  end

  // pc only moves on an accepted fetch, so the address is stable across WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= RESET_PC;
      if_valid         <= 1'b0;
      if_pc            <= '0;
      redirect_pending <= 1'b0;
      pend_tgt         <= '0;
    end
`ifdef PC_EXC_EN
    else if (exc_req) begin
      pc               <= EXC_VECTOR;
      redirect_pending <= 1'b0;
      if_valid         <= 1'b0;
    end
`endif
    else begin
      if_valid <= accept;
      if (accept) begin
        if_pc <= pc;
        if (redirect_pending) begin
          pc               <= pend_tgt;
          redirect_pending <= 1'b0;
        end else if (redir) begin
          pc <= target;
        end else begin
          pc <= pc + INSN_BYTES;
        end
      end else if (redir && !redirect_pending) begin
        // the delay-slot fetch has not gone out yet; hold the target until it does
        pend_tgt         <= target;
        redirect_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected fetch PCs are queued by the
// stimulus and popped by a monitor on every if_valid pulse.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [15:0] br_imm16;
  logic [31:0] id_pc;
  logic        jump;
  logic [25:0] j_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        imem_ready;
`ifdef PC_EXC_EN
  logic        exc_req;
`endif
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        redirect_pending;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch           (branch),
    .br_imm16         (br_imm16),
    .id_pc            (id_pc),
    .jump             (jump),
    .j_index          (j_index),
    .jr               (jr),
    .jr_target        (jr_target),
    .imem_ready       (imem_ready),
`ifdef PC_EXC_EN
    .exc_req          (exc_req),
`endif
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .redirect_pending (redirect_pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redir();
    branch = 1'b0; jump = 1'b0; jr = 1'b0;
  endtask

  // monitor: every accepted fetch must match the head of the queue
  always @(negedge clk) begin
    if (if_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_fetch: got if_pc %h expected no fetch", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (if_pc !== e) begin
          fails++;
          $display("FAIL fetch_order: got if_pc %h expected %h", if_pc, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    branch = 1'b0; br_imm16 = '0; id_pc = '0;
    jump = 1'b0; j_index = '0; jr = 1'b0; jr_target = '0;
`ifdef PC_EXC_EN
    exc_req = 1'b0;
`endif
    tick(); tick();
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ifpc", if_pc, 32'd0);
    chk("rst_pending", {31'd0, redirect_pending}, 32'd0);

    // sequential fetch after reset
    reset = 1'b0;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    tick();
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h3000);
    tick(); tick();

    // branch taken with ready: delay slot 0x3008 then 0x3008+12
    branch = 1'b1; id_pc = 32'h3004; br_imm16 = 16'h0003;
    exp_q.push_back(32'h3008); exp_q.push_back(32'h3014);
    tick();
    clear_redir();
    chk("br_pending", {31'd0, redirect_pending}, 32'd0);
    chk("br_addr", imem_addr, 32'h3014);
    tick();

    // backward branch while imem not ready: target latched, addr held
    imem_ready = 1'b0;
    branch = 1'b1; id_pc = 32'h3004; br_imm16 = 16'hFFFE;
    tick();
    clear_redir();
    chk("wait_pending", {31'd0, redirect_pending}, 32'd1);
    chk("wait_addr1", imem_addr, 32'h3018);
    stall = 1'b1;
    tick();
    chk("wait_addr2", imem_addr, 32'h3018);
    chk("wait_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0; imem_ready = 1'b1;
    exp_q.push_back(32'h3018); exp_q.push_back(32'h3000);
    tick();
    chk("pend_clear", {31'd0, redirect_pending}, 32'd0);
    chk("pend_addr", imem_addr, 32'h3000);
    tick();

    // stall with branch asserted: nothing accepted, branch ignored
    stall = 1'b1; branch = 1'b1; id_pc = 32'h3100; br_imm16 = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", imem_addr, 32'h3004);
      chk("stall_valid", {31'd0, if_valid}, 32'd0);
    end
    chk("stall_pending", {31'd0, redirect_pending}, 32'd0);
    stall = 1'b0; clear_redir();
    exp_q.push_back(32'h3004); exp_q.push_back(32'h3008);
    tick(); tick();

    // jump: {(0x3014)[31:28], 0xC10, 00} = 0x3040
    jump = 1'b1; id_pc = 32'h3010; j_index = 26'h0000C10;
    exp_q.push_back(32'h300C); exp_q.push_back(32'h3040);
    tick();
    clear_redir();
    tick();

    // jr beats jump and branch; low bits of jr_target dropped
    jr = 1'b1; jr_target = 32'h3FFF; jump = 1'b1; branch = 1'b1; br_imm16 = 16'h0001;
    exp_q.push_back(32'h3044); exp_q.push_back(32'h3FFC);
    tick();
    clear_redir();
    tick();

    // jump beats branch
    jump = 1'b1; branch = 1'b1; id_pc = 32'h3010; br_imm16 = 16'h0005;
    exp_q.push_back(32'h4000); exp_q.push_back(32'h3040);
    tick();
    clear_redir();
    tick();

    // branch target wraps modulo 2^32: 0xFFFFFFFC + 8 = 0x4
    branch = 1'b1; id_pc = 32'hFFFF_FFF8; br_imm16 = 16'h0002;
    exp_q.push_back(32'h3044); exp_q.push_back(32'h0000_0004);
    tick();
    clear_redir();
    tick();

    // reset asynchronously while in WAIT with a redirect pending
    imem_ready = 1'b0;
    branch = 1'b1; id_pc = 32'h3004; br_imm16 = 16'hFFFE;
    tick();
    clear_redir();
    tick();
    chk("pre_rst_pending", {31'd0, redirect_pending}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h0000_0008);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_addr", imem_addr, 32'h3000);
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pending", {31'd0, redirect_pending}, 32'd0);
    chk("async_rst_ifpc", if_pc, 32'd0);
    tick();
    reset = 1'b0; imem_ready = 1'b1;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    tick(); tick(); tick();

`ifdef PC_EXC_EN
    // exception in WAIT abandons the outstanding fetch
    imem_ready = 1'b0;
    tick();
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    chk("exc_addr", imem_addr, 32'h0000_4180);
    chk("exc_pending", {31'd0, redirect_pending}, 32'd0);
    imem_ready = 1'b1;
    exp_q.push_back(32'h0000_4180);
    tick();
`endif

    imem_ready = 1'b0;
    tick(); tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side PC controller for the 5-stage MIPS pipeline.
- Consumes the ID-stage branch decision and the jump/jr requests, computes the redirect target, and sequences instruction-memory fetches with a ready handshake.
- Honours the single branch delay slot: a redirect takes effect after exactly one more accepted fetch.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first fetch after reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hazard-unit stall; IF/ID holds and no fetch is accepted
- branch  input  1  ID-stage branch taken, from the comparator
- br_imm16  input  16  branch offset field of the ID instruction
- id_pc  input  32  PC of the instruction in ID
- jump  input  1  ID instruction is j/jal
- j_index  input  26  jump index field
- jr  input  1  ID instruction is jr/jalr
- jr_target  input  32  forwarded rs value
- imem_ready  input  1  instruction memory accepts/completes the current request
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address (= pc register)
- if_valid  output  1  registered one-cycle pulse: a fetch was accepted
- if_pc  output  32  PC of the last accepted fetch
- redirect_pending  output  1  a redirect is latched and waiting for the delay-slot fetch

Behaviour:
- Reset (asynchronous) values: pc=RESET_PC, state=BOOT, imem_req=0, if_valid=0, if_pc=0, redirect_pending=0, pend_tgt=0.
- States:
  - BOOT -> RUN on the first edge after reset is released.
  - RUN/WAIT: imem_req=1.
  - RUN -> WAIT when imem_ready=0.
  - WAIT -> RUN when imem_ready=1.
- Accept condition: accept = (state!=BOOT) && imem_ready && !stall.
- On accept: if_valid<=1 and if_pc<=pc. Otherwise if_valid<=0 and if_pc holds.
- Address stability: imem_addr=pc and changes only on accept (or reset). It stays stable throughout WAIT, regardless of stall toggling.
- Redirect request: redir = (branch|jump|jr) && !stall. It is ignored while stall=1, because ID is not advancing.
- Target priority when several inputs are asserted: jr > jump > branch.
  - branch target: id_pc + 4 + {{14{imm[15]}}, imm, 2'b00}.
  - jump target: {(id_pc+4)[31:28], j_index, 2'b00}.
  - jr target: {jr_target[31:2], 2'b00}.
- All adds are 32-bit and wrap modulo 2^32.
- Next-pc selection on accept:
  - If redirect_pending: pc<=pend_tgt and redirect_pending<=0.
  - Else if redir in the same cycle: pc<=target (the instruction being accepted is the delay slot).
  - Else: pc<=pc+4.
- Redirect without accept: if redir occurs without accept (imem not ready) and pending=0, then pend_tgt<=target and redirect_pending<=1.
- A redir while pending=1 is ignored; pend_tgt is kept.
- Reset mid-WAIT or with a redirect pending clears everything to the reset values. No partial state is retained.

Optional Feature:
- Macro: PC_EXC_EN.
- When defined:
  - Adds input exc_req (1 bit), which has top priority.
  - On the next edge: pc<=32'h0000_4180, redirect_pending<=0, if_valid<=0, state<=RUN.
  - This holds even in WAIT; the outstanding fetch is abandoned.
- When undefined: the port is absent and exception logic is not synthesised.

Decomposition:
- Package pc_pkg:
  - state enum {BOOT, RUN, WAIT}
  - EXC_VECTOR=32'h0000_4180
  - DEFAULT_RESET_PC=32'h0000_3000
  - opcode-independent width constants
- One combinational sub-module, npc_target: computes the branch/jump/jr target and applies the priority mux.
- The pending register and the FSM stay in fetch_pc_unit.

Test Plan:
1. Reset held, then released with imem_ready=1 and stall=0 -> while in reset, imem_addr=0x3000 and imem_req=0; after release, if_pc=0x3000, 0x3004, 0x3008 on consecutive if_valid pulses.
2. branch=1, id_pc=0x3004, imm=0x0003 while fetching 0x3008 with ready=1 -> accepted sequence 0x3008 then 0x3014; redirect_pending stays 0.
3. branch=1, id_pc=0x3004, imm=0xFFFE, with ready=0 for 2 cycles -> redirect_pending=1, imem_addr held at 0x3008; after ready rises, 0x3008 is accepted, then 0x3000, and pending clears.
4. stall=1 for 3 cycles with ready=1 and branch=1 asserted during the stall -> pc held, if_valid=0, branch ignored; sequential fetch resumes afterwards.
5. jump with id_pc=0x3010, j_index=0x0000C10 -> delay slot 0x3014, then 0x3040. jr with jr_target=0x3FFF -> delay slot, then 0x3FFC.
6. reset asserted in WAIT with redirect_pending=1 -> outputs return to reset values immediately; first fetch after release is 0x3000. With PC_EXC_EN defined, exc_req in WAIT -> imem_addr=0x4180 on the next edge.
